// File: rtl/main_control_if.sv
// rtl/main_control_if.sv - control-unit to datapath signal bundle for the multicycle MIPS controller
interface main_control_if;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic [1:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic       IorD;
  logic       RegDst;
  logic       MemtoReg;
  logic       IRWrite;
  logic       PCWrite;
  logic       Branch;
  logic       MemWrite;
  logic       RegWrite;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  Opcode, mem_ready,
    output ALUOp, ALUSrcA, ALUSrcB, PCSrc, IorD, RegDst, MemtoReg,
           IRWrite, PCWrite, Branch, MemWrite, RegWrite, illegal_op, state
  );

  modport slave (
    output Opcode, mem_ready,
    input  ALUOp, ALUSrcA, ALUSrcB, PCSrc, IorD, RegDst, MemtoReg,
           IRWrite, PCWrite, Branch, MemWrite, RegWrite, illegal_op, state
  );
endinterface

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multicycle MIPS main controller FSM; ANDI_SUPPORT_EN enables the andi path
module main_control_fsm (
  input  logic               clk,
  input  logic               rst_n,
  main_control_if.master     ctl
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_IMMWB    = 4'd10,
    S_JUMP     = 4'd11,
    S_ANDIEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] w_alu_op;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_pc_src;
  logic       w_iord;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_branch;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = S_FETCH;
    w_alu_op     = 2'b00;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_pc_src     = 2'b00;
    w_iord       = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_alu_src_b  = 2'b01;
        // Fetch strobes only fire on the cycle memory actually returns the word
        w_ir_write   = ctl.mem_ready;
        w_pc_write   = ctl.mem_ready;
        w_next_state = ctl.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_alu_src_b = 2'b11;
        case (ctl.Opcode)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXECUTE;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_J:         w_next_state = S_JUMP;
`ifdef ANDI_SUPPORT_EN
          OP_ANDI:      w_next_state = S_ANDIEX;
`endif
          default: begin
            w_illegal    = 1'b1;
            w_next_state = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        if (ctl.Opcode == OP_LW) begin
          w_next_state = S_MEMREAD;
        end else if (ctl.Opcode == OP_SW) begin
          w_next_state = S_MEMWRITE;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_MEMREAD: begin
        w_iord       = 1'b1;
        w_next_state = ctl.mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        w_iord       = 1'b1;
        w_mem_write  = 1'b1;
        w_next_state = ctl.mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTE: begin
        w_alu_src_a  = 1'b1;
        w_alu_op     = 2'b10;
        w_next_state = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b01;
        w_pc_src    = 2'b01;
        w_branch    = 1'b1;
      end
      S_ADDIEX: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_next_state = S_IMMWB;
      end
`ifdef ANDI_SUPPORT_EN
      S_ANDIEX: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_alu_op     = 2'b11;
        w_next_state = S_IMMWB;
      end
`endif
      S_IMMWB: begin
        w_reg_write = 1'b1;
      end
      S_JUMP: begin
        w_pc_src   = 2'b10;
        w_pc_write = 1'b1;
      end
      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  assign ctl.ALUOp    = w_alu_op;
  assign ctl.ALUSrcA  = w_alu_src_a;
  assign ctl.ALUSrcB  = w_alu_src_b;
  assign ctl.PCSrc    = w_pc_src;
  assign ctl.IorD     = w_iord;
  assign ctl.RegDst   = w_reg_dst;
  assign ctl.MemtoReg = w_mem_to_reg;
  assign ctl.state    = r_state;

  // Strobes are gated by reset so nothing writes while rst_n is low, even with mem_ready high in FETCH
  assign ctl.IRWrite    = w_ir_write  & rst_n;
  assign ctl.PCWrite    = w_pc_write  & rst_n;
  assign ctl.Branch     = w_branch    & rst_n;
  assign ctl.MemWrite   = w_mem_write & rst_n;
  assign ctl.RegWrite   = w_reg_write & rst_n;
  assign ctl.illegal_op = w_illegal   & rst_n;

endmodule

// File: tb/tb_main_control_fsm.sv
// tb/tb_main_control_fsm.sv - directed self-checking bench for main_control_fsm
module tb_main_control_fsm;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   cyc;

  logic [3:0] t_state [0:63];
  logic [1:0] t_aluop [0:63];
  logic [1:0] t_pcsrc [0:63];
  logic       t_irw   [0:63];
  logic       t_pcw   [0:63];
  logic       t_br    [0:63];
  logic       t_mw    [0:63];
  logic       t_rw    [0:63];
  logic       t_m2r   [0:63];
  logic       t_iord  [0:63];
  logic       t_rdst  [0:63];
  logic       t_ill   [0:63];

  main_control_if u_if ();

  main_control_fsm u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_seq(input string tag, input logic [31:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s state[%0d]", tag, i), {28'd0, t_state[i]}, {28'd0, seq[4*(n-1-i) +: 4]});
    end
  endtask

  // Runs one instruction from FETCH until FETCH is re-entered, capturing outputs each cycle.
  task automatic run(input string tag, input logic [5:0] op, input logic [3:0] stall_st,
                     input int stall_n, output int ncyc);
    int  stalls;
    bit  done;
    stalls = stall_n;
    ncyc   = 0;
    done   = 0;
    u_if.Opcode = op;
    for (int k = 0; k < 40 && !done; k++) begin
      if (u_if.state == stall_st && stalls > 0) begin
        u_if.mem_ready = 1'b0;
        stalls--;
      end else begin
        u_if.mem_ready = 1'b1;
      end
      #1;
      t_state[ncyc] = u_if.state;
      t_aluop[ncyc] = u_if.ALUOp;
      t_pcsrc[ncyc] = u_if.PCSrc;
      t_irw[ncyc]   = u_if.IRWrite;
      t_pcw[ncyc]   = u_if.PCWrite;
      t_br[ncyc]    = u_if.Branch;
      t_mw[ncyc]    = u_if.MemWrite;
      t_rw[ncyc]    = u_if.RegWrite;
      t_m2r[ncyc]   = u_if.MemtoReg;
      t_iord[ncyc]  = u_if.IorD;
      t_rdst[ncyc]  = u_if.RegDst;
      t_ill[ncyc]   = u_if.illegal_op;
      @(posedge clk);
      @(negedge clk);
      ncyc++;
      if (u_if.state == 4'd0 && t_state[ncyc-1] != 4'd0) done = 1;
    end
    chk({tag, " completes"}, {31'd0, done}, 32'd1);
    u_if.mem_ready = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    u_if.mem_ready = 1'b1;
    u_if.Opcode    = 6'b000000;
    #3;
    chk("reset state",   {28'd0, u_if.state},   32'd0);
    chk("reset IRWrite", {31'd0, u_if.IRWrite}, 32'd0);
    chk("reset PCWrite", {31'd0, u_if.PCWrite}, 32'd0);
    chk("reset ALUSrcB", {30'd0, u_if.ALUSrcB}, 32'd1);
    chk("reset illegal", {31'd0, u_if.illegal_op}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // lw, zero wait states
    run("lw", 6'b100011, 4'hF, 0, cyc);
    chk("lw cycles", cyc, 5);
    chk_seq("lw", 32'h01234, 5);
    chk("lw IRWrite fetch", {31'd0, t_irw[0]}, 32'd1);
    chk("lw IorD memread",  {31'd0, t_iord[3]}, 32'd1);
    chk("lw RegWrite memread", {31'd0, t_rw[3]}, 32'd0);
    chk("lw MemtoReg memwb", {31'd0, t_m2r[4]}, 32'd1);
    chk("lw RegWrite memwb", {31'd0, t_rw[4]}, 32'd1);
    chk("lw MemtoReg decode", {31'd0, t_m2r[1]}, 32'd0);

    // sw with three stalled cycles in MEMWRITE
    run("sw", 6'b101011, 4'd5, 3, cyc);
    chk("sw cycles", cyc, 7);
    chk_seq("sw", 32'h0125555, 7);
    chk("sw MemWrite count", t_mw[3] + t_mw[4] + t_mw[5] + t_mw[6], 4);
    chk("sw MemWrite memadr", {31'd0, t_mw[2]}, 32'd0);

    // R-type then beq
    run("rtype", 6'b000000, 4'hF, 0, cyc);
    chk("rtype cycles", cyc, 4);
    chk_seq("rtype", 32'h0167, 4);
    chk("rtype ALUOp execute", {30'd0, t_aluop[2]}, 32'd2);
    chk("rtype RegDst aluwb", {31'd0, t_rdst[3]}, 32'd1);
    chk("rtype RegWrite aluwb", {31'd0, t_rw[3]}, 32'd1);

    run("beq", 6'b000100, 4'hF, 0, cyc);
    chk("beq cycles", cyc, 3);
    chk_seq("beq", 32'h018, 3);
    chk("beq ALUOp", {30'd0, t_aluop[2]}, 32'd1);
    chk("beq Branch", {31'd0, t_br[2]}, 32'd1);
    chk("beq PCSrc", {30'd0, t_pcsrc[2]}, 32'd1);

    // beq with a two-cycle fetch stall
    run("beq stall", 6'b000100, 4'd0, 2, cyc);
    chk("beq stall cycles", cyc, 5);
    chk("beq stall IRWrite 0", {31'd0, t_irw[0]}, 32'd0);
    chk("beq stall PCWrite 1", {31'd0, t_pcw[1]}, 32'd0);
    chk("beq stall IRWrite 2", {31'd0, t_irw[2]}, 32'd1);

    run("j", 6'b000010, 4'hF, 0, cyc);
    chk("j cycles", cyc, 3);
    chk_seq("j", 32'h01B, 3);
    chk("j PCWrite", {31'd0, t_pcw[2]}, 32'd1);
    chk("j PCSrc", {30'd0, t_pcsrc[2]}, 32'd2);

    run("addi", 6'b001000, 4'hF, 0, cyc);
    chk("addi cycles", cyc, 4);
    chk_seq("addi", 32'h019A, 4);
    chk("addi RegWrite immwb", {31'd0, t_rw[3]}, 32'd1);
    chk("addi RegDst immwb", {31'd0, t_rdst[3]}, 32'd0);

    // illegal opcode
    run("illegal", 6'b111111, 4'hF, 0, cyc);
    chk("illegal cycles", cyc, 2);
    chk_seq("illegal", 32'h01, 2);
    chk("illegal pulse decode", {31'd0, t_ill[1]}, 32'd1);
    chk("illegal fetch", {31'd0, t_ill[0]}, 32'd0);
    chk("illegal strobes", {31'd0, t_rw[1] | t_mw[1] | t_pcw[1] | t_irw[1] | t_br[1]}, 32'd0);
    chk("illegal after", {31'd0, u_if.illegal_op}, 32'd0);

`ifdef ANDI_SUPPORT_EN
    run("andi", 6'b001100, 4'hF, 0, cyc);
    chk("andi cycles", cyc, 4);
    chk_seq("andi", 32'h01CA, 4);
    chk("andi ALUOp", {30'd0, t_aluop[2]}, 32'd3);
`else
    run("andi", 6'b001100, 4'hF, 0, cyc);
    chk("andi cycles", cyc, 2);
    chk_seq("andi", 32'h01, 2);
    chk("andi illegal", {31'd0, t_ill[1]}, 32'd1);
`endif

    // async reset in the middle of MEMWB
    u_if.Opcode    = 6'b100011;
    u_if.mem_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("midrst pre state", {28'd0, u_if.state}, 32'd4);
    chk("midrst pre RegWrite", {31'd0, u_if.RegWrite}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst state",    {28'd0, u_if.state},    32'd0);
    chk("midrst RegWrite", {31'd0, u_if.RegWrite}, 32'd0);
    chk("midrst ALUSrcB",  {30'd0, u_if.ALUSrcB},  32'd1);
    chk("midrst IRWrite",  {31'd0, u_if.IRWrite},  32'd0);
    @(negedge clk);
    chk("midrst hold state", {28'd0, u_if.state}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post rst IRWrite", {31'd0, u_if.IRWrite}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("post rst decode", {28'd0, u_if.state}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multicycle MIPS main controller; the producer side of the 2-bit `ALUOp` interface that the ALU decoder consumes.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath strobe and mux select.
- Waits on a memory ready handshake during fetch, data read and data write.
- Sits in the Control_Unit beside the ALU decoder and feeds `ALUOp` to it directly.

## Interface
Parameters: none.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous reset, active-low.
- `Opcode` input 6: instr[31:26] from the instruction register.
- `mem_ready` input 1: memory completes the current access this cycle.
- `ALUOp` output 2: 00 add, 01 sub, 10 use funct, 11 and.
- `ALUSrcA` output 1: 0 = PC, 1 = register A.
- `ALUSrcB` output 2: 00 = B, 01 = const 4, 10 = imm, 11 = imm<<2.
- `PCSrc` output 2: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `IorD`, `RegDst`, `MemtoReg` outputs 1 each: datapath mux selects.
- `IRWrite`, `PCWrite`, `Branch`, `MemWrite`, `RegWrite` outputs 1 each: write strobes.
- `illegal_op` output 1: one-cycle pulse when DECODE sees an unsupported opcode.
- `state` output 4: current state encoding, for debug.

## Operation
- Moore FSM. Outputs decode from `state` only, except the fetch strobes, which are qualified by `mem_ready`. Any output not listed for a state is 0.
- State encodings:
  - FETCH 0
  - DECODE 1
  - MEMADR 2
  - MEMREAD 3
  - MEMWB 4
  - MEMWRITE 5
  - EXECUTE 6
  - ALUWB 7
  - BRANCH 8
  - ADDIEX 9
  - IMMWB 10
  - JUMP 11
  - ANDIEX 12
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=PCWrite=`mem_ready`. Goes to DECODE when `mem_ready`=1, otherwise holds.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by `Opcode`:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → EXECUTE
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JUMP
  - 001100 (andi) → ANDIEX
  - anything else → FETCH, with `illegal_op`=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMREAD if lw, MEMWRITE if sw.
- MEMREAD: IorD=1. Holds until `mem_ready`, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Then FETCH.
- MEMWRITE: IorD=1, MemWrite=1. Holds until `mem_ready`, then FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Then ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Then FETCH. The datapath forms the taken condition as Branch & Zero.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Then IMMWB.
- ANDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=11. Then IMMWB.
- IMMWB: RegDst=0, MemtoReg=0, RegWrite=1. Then FETCH.
- JUMP: PCSrc=10, PCWrite=1. Then FETCH.
- Any unencoded state value (13–15) → FETCH next cycle with all strobes 0.

## Timing
- Reset: `rst_n` low asynchronously forces `state`=FETCH.
  - While `rst_n`=0, all write strobes and `illegal_op` are forced to 0.
  - Mux selects and `ALUOp` hold their FETCH values.
- First FETCH can complete on the first rising edge after `rst_n` rises.
- Cycle counts with zero wait states (`mem_ready` tied 1): lw 5; sw, R-type, addi, andi 4; beq, j 3.
- Each cycle `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
  - In FETCH, IRWrite and PCWrite stay low until the ready cycle.
  - In MEMWRITE, MemWrite stays high for the whole hold.
- `mem_ready` is ignored in every other state.
- `Opcode` is sampled only in DECODE and MEMADR, and must be stable there; IRWrite is low in both states.
- `rst_n` asserted mid-instruction abandons it immediately. No strobe glitches high after reset is asserted.

## Configuration
- `ANDI_SUPPORT_EN` defined: andi decodes to ANDIEX, which is the only state driving ALUOp=11.
- `ANDI_SUPPORT_EN` undefined:
  - ANDIEX is not built.
  - Opcode 001100 is treated as illegal (`illegal_op` pulse, return to FETCH).
  - ALUOp never takes the value 11.

## Test plan
- Reset with `rst_n`=0 mid-MEMWB → `state`=0 the same cycle, RegWrite=0, ALUSrcB=01.
- lw (Opcode 100011), `mem_ready`=1 → states 0,1,2,3,4,0. MemtoReg=1 and RegWrite=1 only in state 4.
- sw with `mem_ready` low for 3 cycles in MEMWRITE → MemWrite high 4 cycles. Total sw latency 7 cycles.
- R-type then beq → ALUOp 10 in EXECUTE, ALUOp 01 with Branch=1 and PCSrc=01 in BRANCH. Latencies 4 and 3 cycles.
- Opcode 111111 → `illegal_op`=1 for one cycle in DECODE, next state 0, no write strobe asserted.
- andi (001100) with `ANDI_SUPPORT_EN` defined → states 0,1,12,10, ALUOp=11 in state 12. Without the macro → `illegal_op` pulse and return to 0.
